// File: rtl/seven_seg_scanner_if.sv
// Board-side bundle of the scanner: controls and memory word in, address and display pins out.
// Latency: none (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface seven_seg_scanner_if #(
  parameter int N_DIGITS = 8,
  parameter int ADDR_W   = 8
);
  logic [1:0]            status;
  logic                  dir;
  logic                  step;
  logic [4*N_DIGITS-1:0] data;
  logic [ADDR_W-1:0]     addr;
  logic                  jump;
  logic [N_DIGITS-1:0]   anode;
  logic [6:0]            cathode;
  logic                  dp;

  // Board / memory side: drives controls and the fetched word, observes address and pins.
  modport master (
    output status, dir, step, data,
    input  addr, jump, anode, cathode, dp
  );

  // Scanner side.
  modport slave (
    input  status, dir, step, data,
    output addr, jump, anode, cathode, dp
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Steps a memory address at a selectable speed and scans the fetched hex word over N_DIGITS 7-seg digits.
// Latency: addr/jump update one edge after a step decision; a digit appears SCAN_DIV cycles after its slot starts.
// Backpressure: none; step is honoured only while paused, display scan is free-running.
module seven_seg_scanner #(
  parameter int                N_DIGITS = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(255),
  parameter int                ONE_JUMP = 100_000_000,
  parameter int                SCAN_DIV = 100_000,
  parameter bit                BLANK_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  seven_seg_scanner_if.slave bus
);

  localparam int JW = (ONE_JUMP > 1) ? $clog2(ONE_JUMP) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [JW-1:0] JMP_LAST  = JW'(ONE_JUMP - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(N_DIGITS - 1);

  logic [3:0]          pre_q, pre_d, limit;
  logic                tick;
  logic [JW-1:0]       jmp_q, jmp_d;
  logic                adv;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                jump_q;
  logic [SW-1:0]       scan_q, scan_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]          cath_q, cath_d;
  logic [3:0]          nib;
  logic                all_zero, blank;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Prescaler: >= compare so a limit lowered mid-count fires at once instead of wrapping.
  always_comb begin
    tick  = 1'b0;
    pre_d = pre_q + 4'd1;
    case (bus.status)
      2'd0:    limit = 4'd15;
      2'd1:    limit = 4'd3;
      default: limit = 4'd0;
    endcase
    if (bus.status == 2'd3) begin
      pre_d = 4'd0;
    end else if (pre_q >= limit) begin
      tick  = 1'b1;
      pre_d = 4'd0;
    end
  end

  // Jump period and address stepping; jmp_cnt holds through a pause so the period resumes.
  always_comb begin
    jmp_d  = jmp_q;
    adv    = 1'b0;
    addr_d = addr_q;
    if (tick) begin
      if (jmp_q == JMP_LAST) begin
        jmp_d = '0;
        adv   = 1'b1;
      end else begin
        jmp_d = jmp_q + JW'(1);
      end
    end
    if (bus.status == 2'd3 && bus.step) adv = 1'b1;
    if (adv) begin
      if (bus.dir) addr_d = (addr_q == '0) ? ADDR_MAX : addr_q - ADDR_W'(1);
      else         addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // Pick the nibble for the digit being loaded and decide leading-zero blanking.
  always_comb begin
    nib      = 4'd0;
    all_zero = 1'b1;
    blank    = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (bus.data[4*k +: 4] == 4'd0);
      if (dig_q == DW'(k)) begin
        nib   = bus.data[4*k +: 4];
        blank = BLANK_LZ && (k != 0) && all_zero;
      end
    end
  end

  // Scan: anode and cathode load together at the slot boundary so segments never ghost.
  always_comb begin
    scan_d  = scan_q + SW'(1);
    dig_d   = dig_q;
    anode_d = anode_q;
    cath_d  = cath_q;
    if (scan_q == SCAN_LAST) begin
      scan_d         = '0;
      dig_d          = (dig_q == DIG_LAST) ? '0 : dig_q + DW'(1);
      anode_d        = '1;
      anode_d[dig_q] = 1'b0;
      cath_d         = blank ? 7'h7F : hex7(nib);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q   <= '0;
      jmp_q   <= '0;
      addr_q  <= '0;
      jump_q  <= 1'b0;
      scan_q  <= '0;
      dig_q   <= '0;
      anode_q <= '1;
      cath_q  <= 7'h7F;
    end else begin
      pre_q   <= pre_d;
      jmp_q   <= jmp_d;
      addr_q  <= addr_d;
      jump_q  <= adv;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      anode_q <= anode_d;
      cath_q  <= cath_d;
    end
  end

  assign bus.addr    = addr_q;
  assign bus.jump    = jump_q;
  assign bus.anode   = anode_q;
  assign bus.cathode = cath_q;
  assign bus.dp      = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: stepping speeds, wrap, pause/step, scan/decode and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_seven_seg_scanner;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seven_seg_scanner_if #(.N_DIGITS(4), .ADDR_W(8)) bus ();

  seven_seg_scanner #(
    .N_DIGITS(4), .ADDR_W(8), .ADDR_MAX(8'd3),
    .ONE_JUMP(4), .SCAN_DIV(2), .BLANK_LZ(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected values after edges 1..8 following reset release (status=2, data=16'h00A0).
  logic [7:0] exp_addr [8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
  logic       exp_jump [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] exp_an   [8] = '{4'hF, 4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7};
  logic [6:0] exp_cat  [8] = '{7'h7F, 7'h40, 7'h40, 7'h08, 7'h08, 7'h7F, 7'h7F, 7'h7F};

  initial begin
    logic jump_seen;
    rst_n      = 1'b0;
    bus.status = 2'd2;
    bus.dir    = 1'b0;
    bus.step   = 1'b0;
    bus.data   = 16'h00A0;
    repeat (2) tick();
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_jump", 32'(bus.jump), 32'd0);
    check("rst_anode", 32'(bus.anode), 32'hF);
    check("rst_cathode", 32'(bus.cathode), 32'h7F);
    check("rst_dp", 32'(bus.dp), 32'd1);

    // Fast speed with ONE_JUMP=4, plus the scan sequence.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("fast_addr_%0d", i + 1), 32'(bus.addr), 32'(exp_addr[i]));
      check($sformatf("fast_jump_%0d", i + 1), 32'(bus.jump), 32'(exp_jump[i]));
      check($sformatf("scan_anode_%0d", i + 1), 32'(bus.anode), 32'(exp_an[i]));
      check($sformatf("scan_cath_%0d", i + 1), 32'(bus.cathode), 32'(exp_cat[i]));
    end

    // Wrap at ADDR_MAX=3 in both directions.
    repeat (4) tick();
    check("up_to_3", 32'(bus.addr), 32'd3);
    repeat (4) tick();
    check("wrap_up_0", 32'(bus.addr), 32'd0);
    bus.dir = 1'b1;
    repeat (4) tick();
    check("wrap_down_3", 32'(bus.addr), 32'd3);
    repeat (4) tick();
    check("down_2", 32'(bus.addr), 32'd2);

    // Pause holds the address; a step pulse advances it by one.
    bus.status = 2'd3;
    bus.dir    = 1'b0;
    jump_seen  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      jump_seen = jump_seen | bus.jump;
    end
    check("pause_addr", 32'(bus.addr), 32'd2);
    check("pause_no_jump", 32'(jump_seen), 32'd0);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check("step_addr", 32'(bus.addr), 32'd3);
    check("step_jump", 32'(bus.jump), 32'd1);
    tick();
    check("step_jump_clr", 32'(bus.jump), 32'd0);
    bus.status = 2'd2;
    bus.step   = 1'b1;
    tick();
    bus.step = 1'b0;
    check("step_ignored", 32'(bus.addr), 32'd3);

    // Reset in the middle of a scan slot and a jump period.
    rst_n      = 1'b0;
    bus.status = 2'd0;
    tick();
    check("mid_rst_addr", 32'(bus.addr), 32'd0);
    check("mid_rst_jump", 32'(bus.jump), 32'd0);
    check("mid_rst_anode", 32'(bus.anode), 32'hF);
    check("mid_rst_cathode", 32'(bus.cathode), 32'h7F);
    check("mid_rst_dp", 32'(bus.dp), 32'd1);

    // Slow speed: 16 clk per tick, 64 clk per address step.
    rst_n = 1'b1;
    tick();
    check("post_rst_anode1", 32'(bus.anode), 32'hF);
    tick();
    check("post_rst_anode2", 32'(bus.anode), 32'hE);
    repeat (61) tick();
    check("slow_addr_63", 32'(bus.addr), 32'd0);
    tick();
    check("slow_addr_64", 32'(bus.addr), 32'd1);
    check("slow_jump_64", 32'(bus.jump), 32'd1);

    // Switch to mid speed with pre_cnt=4 above the new limit: it must tick at once.
    repeat (20) tick();
    bus.status = 2'd1;
    repeat (8) tick();
    check("mid_switch_hold", 32'(bus.addr), 32'd1);
    tick();
    check("mid_switch_addr", 32'(bus.addr), 32'd2);
    check("mid_switch_jump", 32'(bus.jump), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
